// File: rtl/mips_mem_pkg.sv
// Shared constants, FSM state type and address helper for the MEM-stage
// store buffer and its load-forwarding match logic.
package mips_mem_pkg;

    localparam int WORD_W        = 32;
    localparam int MEM_BYTES_DEF = 1024;
    localparam int SB_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } sb_state_t;

    // Clear the byte offset so every entry and probe names a whole word.
    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
        return addr & ~WORD_W'(3);
    endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Compares a load probe against every valid store-buffer entry.
// Ports: ld_req_in/ld_addr_in probe (aligned), valid_in/addr_in entry
// state, hit_out any match; with STORE_FWD_EN also head_in (oldest slot)
// and sel_out (slot of the youngest matching entry).
module sb_fwd_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic              ld_req_in,
    input  logic [WORD_W-1:0] ld_addr_in,
    input  logic [DEPTH-1:0]  valid_in,
    input  logic [WORD_W-1:0] addr_in [DEPTH],
`ifdef STORE_FWD_EN
    input  logic [PW-1:0]     head_in,
    output logic [PW-1:0]     sel_out,
`endif
    output logic              hit_out
);

`ifdef STORE_FWD_EN
    // Walk slots from oldest to youngest; a later match overrides an
    // earlier one, so the youngest matching store is selected.
    always_comb begin
        logic [PW-1:0] idx;
        hit_out = 1'b0;
        sel_out = head_in;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_in + PW'(k);
            if (ld_req_in && valid_in[idx] && addr_in[idx] == ld_addr_in) begin
                hit_out = 1'b1;
                sel_out = idx;
            end
        end
    end
`else
    // Without forwarding only the existence of a match matters.
    always_comb begin
        hit_out = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ld_req_in && valid_in[k] && addr_in[k] == ld_addr_in) begin
                hit_out = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/store_buffer.sv
// MEM-stage store buffer: queues word stores, drains them to data memory
// one per cycle, and checks loads against pending stores.
// Ports: clk, reset (sync, active-low); st_* store enqueue handshake;
// ld_* load probe and forward result; mem_* memory write port with hold;
// drain_in/drain_done_out flush handshake; range_err_out out-of-range
// store pulse; count_out/full_out/empty_out occupancy.
// Build option: STORE_FWD_EN forwards matching store data to loads;
// without it any match is reported as ld_conflict_out.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH     = SB_DEPTH_DEF,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid_in,
    input  logic [WORD_W-1:0]      st_addr_in,
    input  logic [WORD_W-1:0]      st_data_in,
    output logic                   st_ready_out,
    input  logic                   ld_req_in,
    input  logic [WORD_W-1:0]      ld_addr_in,
    output logic                   ld_hit_out,
    output logic [WORD_W-1:0]      ld_data_out,
    output logic                   ld_conflict_out,
    input  logic                   mem_hold_in,
    output logic                   mem_write_out,
    output logic [WORD_W-1:0]      mem_addr_out,
    output logic [WORD_W-1:0]      mem_data_out,
    input  logic                   drain_in,
    output logic                   drain_done_out,
    output logic                   range_err_out,
    output logic [$clog2(DEPTH):0] count_out,
    output logic                   full_out,
    output logic                   empty_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
    localparam logic [WORD_W-1:0] MEM_LIMIT = WORD_W'(MEM_BYTES);

    sb_state_t         state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [WORD_W-1:0] addr_q [DEPTH];
    logic [WORD_W-1:0] addr_d [DEPTH];
    logic [WORD_W-1:0] data_q [DEPTH];
    logic [WORD_W-1:0] data_d [DEPTH];
    logic              range_err_q, range_err_d;
    logic              drain_done_q, drain_done_d;

    logic [WORD_W-1:0] st_addr_al;
    logic [WORD_W-1:0] ld_addr_al;
    logic              in_range;
    logic              st_fire;
    logic              enq;
    logic              deq;
    logic              fwd_hit;

    assign st_addr_al     = word_align(st_addr_in);
    assign ld_addr_al     = word_align(ld_addr_in);
    assign full_out       = (cnt_q == FULL_CNT);
    assign empty_out      = (cnt_q == '0);
    assign count_out      = cnt_q;
    assign st_ready_out   = !full_out && (state_q != FLUSH);
    assign in_range       = (st_addr_al < MEM_LIMIT);
    // A handshake on an out-of-range address is consumed but dropped.
    assign st_fire        = st_valid_in && st_ready_out;
    assign enq            = st_fire && in_range;
    assign deq            = !empty_out && !mem_hold_in;
    assign mem_write_out  = deq;
    assign mem_addr_out   = addr_q[rd_ptr_q];
    assign mem_data_out   = data_q[rd_ptr_q];
    assign range_err_out  = range_err_q;
    assign drain_done_out = drain_done_q;

    // Entry storage and pointers. Enqueue and dequeue never touch the
    // same slot: they coincide only when empty or full, which blocks one.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (enq) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = st_addr_al;
            data_d[wr_ptr_q]  = st_data_in;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(enq) - CW'(deq);
    end

    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        range_err_d  = st_fire && !in_range;
        unique case (state_q)
            IDLE: begin
                if (drain_in) begin
                    if (enq) state_d = FLUSH;
                    else     drain_done_d = 1'b1;
                end else if (enq) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (drain_in) begin
                    if (cnt_d == '0) begin
                        state_d      = IDLE;
                        drain_done_d = 1'b1;
                    end else begin
                        state_d = FLUSH;
                    end
                end else if (cnt_d == '0) begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (cnt_d == '0) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            valid_q      <= '0;
            range_err_q  <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            range_err_q  <= range_err_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

`ifdef STORE_FWD_EN
    logic [PW-1:0] fwd_sel;
`endif

    sb_fwd_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .ld_req_in  (ld_req_in),
        .ld_addr_in (ld_addr_al),
        .valid_in   (valid_q),
        .addr_in    (addr_q),
`ifdef STORE_FWD_EN
        .head_in    (rd_ptr_q),
        .sel_out    (fwd_sel),
`endif
        .hit_out    (fwd_hit)
    );

`ifdef STORE_FWD_EN
    assign ld_hit_out      = fwd_hit;
    assign ld_data_out     = fwd_hit ? data_q[fwd_sel] : '0;
    assign ld_conflict_out = 1'b0;
`else
    assign ld_hit_out      = 1'b0;
    assign ld_data_out     = '0;
    assign ld_conflict_out = fwd_hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, MEM_BYTES=1024).
// Forwarding expectations follow the STORE_FWD_EN build option.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid_in;
    logic [31:0] st_addr_in;
    logic [31:0] st_data_in;
    logic        st_ready_out;
    logic        ld_req_in;
    logic [31:0] ld_addr_in;
    logic        ld_hit_out;
    logic [31:0] ld_data_out;
    logic        ld_conflict_out;
    logic        mem_hold_in;
    logic        mem_write_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        drain_in;
    logic        drain_done_out;
    logic        range_err_out;
    logic [2:0]  count_out;
    logic        full_out;
    logic        empty_out;

    int n_checks = 0;
    int n_errors = 0;

    store_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .st_valid_in     (st_valid_in),
        .st_addr_in      (st_addr_in),
        .st_data_in      (st_data_in),
        .st_ready_out    (st_ready_out),
        .ld_req_in       (ld_req_in),
        .ld_addr_in      (ld_addr_in),
        .ld_hit_out      (ld_hit_out),
        .ld_data_out     (ld_data_out),
        .ld_conflict_out (ld_conflict_out),
        .mem_hold_in     (mem_hold_in),
        .mem_write_out   (mem_write_out),
        .mem_addr_out    (mem_addr_out),
        .mem_data_out    (mem_data_out),
        .drain_in        (drain_in),
        .drain_done_out  (drain_done_out),
        .range_err_out   (range_err_out),
        .count_out       (count_out),
        .full_out        (full_out),
        .empty_out       (empty_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        st_valid_in = 1'b1;
        st_addr_in  = a;
        st_data_in  = d;
        tick();
        st_valid_in = 1'b0;
    endtask

    // Expected probe result for a load that matches a store holding d.
    task automatic check_match(input string tag, input logic [31:0] d);
`ifdef STORE_FWD_EN
        check({tag, "_hit"}, 32'(ld_hit_out), 32'd1);
        check({tag, "_data"}, ld_data_out, d);
        check({tag, "_conf"}, 32'(ld_conflict_out), 32'd0);
`else
        check({tag, "_hit"}, 32'(ld_hit_out), 32'd0);
        check({tag, "_data"}, ld_data_out, 32'd0);
        check({tag, "_conf"}, 32'(ld_conflict_out), 32'd1);
`endif
    endtask

    task automatic check_nomatch(input string tag);
        check({tag, "_hit"}, 32'(ld_hit_out), 32'd0);
        check({tag, "_data"}, ld_data_out, 32'd0);
        check({tag, "_conf"}, 32'(ld_conflict_out), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        st_valid_in = 1'b0;
        st_addr_in  = '0;
        st_data_in  = '0;
        ld_req_in   = 1'b0;
        ld_addr_in  = '0;
        mem_hold_in = 1'b0;
        drain_in    = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full_out), 32'd0);
        check("rst_ready", 32'(st_ready_out), 32'd1);
        check("rst_mwr", 32'(mem_write_out), 32'd0);
        check("rst_rerr", 32'(range_err_out), 32'd0);
        check("rst_ddone", 32'(drain_done_out), 32'd0);

        // Fill to full while memory holds.
        mem_hold_in = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h10 + 32'(4 * i), 32'h100 + 32'(i));
        check("fill_count", 32'(count_out), 32'd4);
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_ready", 32'(st_ready_out), 32'd0);
        check("fill_mwr", 32'(mem_write_out), 32'd0);
        check("fill_head", mem_addr_out, 32'h10);
        push(32'h30, 32'hDEAD);
        check("full_reject", 32'(count_out), 32'd4);
        ld_req_in  = 1'b1;
        ld_addr_in = 32'h16;
        #1;
        check_match("ld14", 32'h101);
        ld_addr_in = 32'h40;
        #1;
        check_nomatch("ld40");
        ld_req_in = 1'b0;

        // Release: one write per cycle, in order.
        mem_hold_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("drn_mwr", 32'(mem_write_out), 32'd1);
            check("drn_addr", mem_addr_out, 32'h10 + 32'(4 * i));
            check("drn_data", mem_data_out, 32'h100 + 32'(i));
            tick();
        end
        check("drn_empty", 32'(empty_out), 32'd1);
        check("drn_mwr0", 32'(mem_write_out), 32'd0);

        // Youngest match wins; same-cycle enqueue does not match.
        mem_hold_in = 1'b1;
        push(32'h20, 32'hAAAA);
        push(32'h22, 32'hBBBB);
        check("yng_count", 32'(count_out), 32'd2);
        ld_req_in  = 1'b1;
        ld_addr_in = 32'h20;
        #1;
        check_match("ld20", 32'hBBBB);
        ld_addr_in  = 32'h24;
        st_valid_in = 1'b1;
        st_addr_in  = 32'h24;
        st_data_in  = 32'hCCCC;
        #1;
        check_nomatch("ld24_same");
        tick();
        st_valid_in = 1'b0;
        #1;
        check_match("ld24_reg", 32'hCCCC);
        ld_req_in   = 1'b0;
        mem_hold_in = 1'b0;
        tick();
        tick();
        tick();
        check("yng_empty", 32'(count_out), 32'd0);

        // Range boundary.
        mem_hold_in = 1'b1;
        push(32'h400, 32'h55);
        check("rng_count", 32'(count_out), 32'd0);
        check("rng_err", 32'(range_err_out), 32'd1);
        push(32'h3FF, 32'h66);
        check("rng_err_clr", 32'(range_err_out), 32'd0);
        check("rng_ok_count", 32'(count_out), 32'd1);
        check("rng_ok_addr", mem_addr_out, 32'h3FC);
        mem_hold_in = 1'b0;
        tick();
        check("rng_empty", 32'(count_out), 32'd0);

        // Drain with three pending stores.
        mem_hold_in = 1'b1;
        push(32'h40, 32'h1);
        push(32'h44, 32'h2);
        push(32'h48, 32'h3);
        drain_in = 1'b1;
        tick();
        drain_in = 1'b0;
        check("fl_ready", 32'(st_ready_out), 32'd0);
        check("fl_count", 32'(count_out), 32'd3);
        mem_hold_in = 1'b0;
        tick();
        check("fl_ready2", 32'(st_ready_out), 32'd0);
        check("fl_done2", 32'(drain_done_out), 32'd0);
        tick();
        check("fl_ready1", 32'(st_ready_out), 32'd0);
        check("fl_done1", 32'(drain_done_out), 32'd0);
        tick();
        check("fl_count0", 32'(count_out), 32'd0);
        check("fl_done", 32'(drain_done_out), 32'd1);
        check("fl_ready0", 32'(st_ready_out), 32'd1);
        tick();
        check("fl_done_clr", 32'(drain_done_out), 32'd0);

        // Drain while already empty.
        drain_in = 1'b1;
        tick();
        drain_in = 1'b0;
        check("fe_done", 32'(drain_done_out), 32'd1);
        tick();
        check("fe_done_clr", 32'(drain_done_out), 32'd0);

        // Reset mid-drain discards pending stores.
        mem_hold_in = 1'b1;
        push(32'h50, 32'h7);
        push(32'h54, 32'h8);
        drain_in = 1'b1;
        tick();
        drain_in = 1'b0;
        reset    = 1'b0;
        tick();
        reset       = 1'b1;
        mem_hold_in = 1'b0;
        #1;
        check("rr_count", 32'(count_out), 32'd0);
        check("rr_mwr", 32'(mem_write_out), 32'd0);
        check("rr_ready", 32'(st_ready_out), 32'd1);
        tick();
        check("rr_mwr2", 32'(mem_write_out), 32'd0);
        check("rr_empty", 32'(empty_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending-store entries (power of two, 2..16).
REQ-002 Parameter MEM_BYTES, default 1024, SHALL set the data-memory size in bytes used for range checking.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-low; reset==0 at a rising clk edge SHALL reset the block.
REQ-005 st_valid_in  input  1  a store request from the MEM stage is present.
REQ-006 st_addr_in / st_data_in  input  32 each  store byte address and store word.
REQ-007 st_ready_out  output  1  the buffer accepts a store this cycle.
REQ-008 ld_req_in  input  1; ld_addr_in  input  32  the load probe from the MEM stage.
REQ-009 ld_hit_out  output  1; ld_data_out  output  32  forwarded load result.
REQ-010 ld_conflict_out  output  1  the load matches a pending store that cannot be forwarded.
REQ-011 mem_hold_in  input  1  the data memory cannot take a write this cycle.
REQ-012 mem_write_out  output  1; mem_addr_out / mem_data_out  output  32 each  write port to the data memory.
REQ-013 drain_in  input  1  request to flush all pending stores.
REQ-014 drain_done_out, range_err_out  output  1 each  one-cycle registered pulses.
REQ-015 count_out  output  $clog2(DEPTH)+1  occupancy; full_out, empty_out  output  1 each.

Function
REQ-016 Addresses SHALL be word-aligned on entry by clearing bits [1:0]; all comparisons SHALL use aligned addresses.
REQ-017 Enqueue SHALL occur when st_valid_in && st_ready_out; st_ready_out = !full && state!=FLUSH.
REQ-018 An aligned store address >= MEM_BYTES SHALL NOT be enqueued, and range_err_out SHALL pulse on the next cycle.
REQ-019 The head entry SHALL drive mem_addr_out/mem_data_out combinationally; mem_write_out = !empty && !mem_hold_in.
REQ-020 The head SHALL dequeue on the edge where mem_write_out==1; the drain rate is one store per cycle.
REQ-021 When full, no store is accepted even if a dequeue occurs in the same cycle; simultaneous enqueue+dequeue when not full SHALL leave count unchanged.
REQ-022 The read and write pointers SHALL wrap modulo DEPTH; the count SHALL distinguish full from empty.
REQ-023 Load match: when ld_req_in is high, ld_addr_in SHALL be compared against all valid registered entries, and the youngest match wins.
REQ-024 A store being enqueued in the same cycle SHALL NOT match; a head entry dequeuing in the same cycle SHALL still match.
REQ-025 With no match, ld_hit_out=0, ld_data_out=0 and ld_conflict_out=0.
REQ-026 The FSM SHALL have states IDLE (empty), ACTIVE (non-empty) and FLUSH, with transitions IDLE->ACTIVE on enqueue and ACTIVE->IDLE when the last entry dequeues without a new enqueue.
REQ-027 drain_in in IDLE or ACTIVE SHALL enter FLUSH; FLUSH->IDLE when count reaches 0, with drain_done_out pulsing on that transition.
REQ-028 drain_in while already empty SHALL pulse drain_done_out on the next cycle.

Reset
REQ-029 Reset SHALL set the state to IDLE, the pointers and count to 0, all entry valid bits to 0, and range_err_out and drain_done_out to 0.
REQ-030 Reset SHALL discard pending stores mid-drain; mem_write_out SHALL be 0 in the cycle after reset.

Configuration
REQ-031 With STORE_FWD_EN defined, a match SHALL set ld_hit_out=1, ld_data_out=matching data and ld_conflict_out=0.
REQ-032 Without STORE_FWD_EN, ld_hit_out=0, ld_data_out=0, ld_conflict_out=1 on any match, and no data mux SHALL be synthesized.

Structure
REQ-033 Package mips_mem_pkg SHALL hold WORD_W=32, MEM_BYTES_DEF=1024, SB_DEPTH_DEF=4, the sb_state_t enum (IDLE/ACTIVE/FLUSH) and a word-align function.
REQ-034 Youngest-match priority logic SHALL be one sub-module, sb_fwd_match.

Verification
REQ-035 Bench: after reset, 4 stores to 0x10,0x14,0x18,0x1C with mem_hold_in=1 -> full_out=1, count=4, st_ready_out=0.
REQ-036 Bench: release mem_hold_in -> writes 0x10..0x1C appear in order on consecutive cycles, then empty_out=1.
REQ-037 Bench: store 0x20=0xAAAA then 0x22=0xBBBB (aligned to 0x20), then load 0x20 -> ld_hit_out=1, data 0xBBBB (FWD_EN) or ld_conflict_out=1 (no FWD_EN).
REQ-038 Bench: store to 0x400 with MEM_BYTES=1024 -> not enqueued, range_err_out pulses once, count stays 0.
REQ-039 Bench: 3 pending stores with drain_in -> st_ready_out=0 until empty, then drain_done_out pulses once.
REQ-040 Bench: reset=0 with 2 pending stores -> count=0, mem_write_out=0 next cycle, and no write issued.
